ddr5_dram_responder: RTL

Single-rank, single-bank DDR5 device responder that sits on the memory side of the DDR5 controller's CA/CS/DQ pins, in the mem_clk domain. It decodes CS/CA commands (ACT, WR, RD, PREab, NOP), stores write bursts in an internal array, and returns read bursts on the bidirectional DQ bus after a fixed read latency. It is the far end of the controller's command and data path. It serves both as the bench memory model and as a synthesizable loopback target for FPGA bring-up.

---
 rtl/ddr5_resp_pkg.sv | 44 ++++
 rtl/ddr5_dram_responder_if.sv | 19 +
 rtl/ddr5_ca_decoder.sv | 47 ++++
 rtl/ddr5_dram_responder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr5_resp_pkg.sv
// ----------------------------------------------------------------------------
// ddr5_resp_pkg
// Shared definitions for the DDR5 DRAM responder:
//   - CA opcode constants (OP_ACT, OP_WR, OP_RD, OP_PREAB, OP_NOP)
//   - FSM state encoding (state_t), exposed on the debug port state_o
//   - decoded command enum (cmd_t) produced by ddr5_ca_decoder
//   - fixed pin widths of the CA / DQ buses and raw address fields
// No ports (package).
// ----------------------------------------------------------------------------
package ddr5_resp_pkg;

   localparam int CA_W        = 14;
   localparam int DQ_W        = 16;
   localparam int ROW_FIELD_W = 12;  // CA[13:2] on ACT
   localparam int COL_FIELD_W = 9;   // CA[13:5] on RD/WR

   // ACT is identified by CA[1:0] alone; the others by CA[4:0].
   localparam logic [1:0] OP_ACT   = 2'b00;
   localparam logic [4:0] OP_WR    = 5'b01101;
   localparam logic [4:0] OP_RD    = 5'b11101;
   localparam logic [4:0] OP_PREAB = 5'b01011;
   localparam logic [4:0] OP_NOP   = 5'b11111;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ACTIVE  = 3'd1,
      WR_WAIT = 3'd2,
      WR_DATA = 3'd3,
      RD_WAIT = 3'd4,
      RD_DATA = 3'd5
   } state_t;

   // CMD_NONE means CS was high: nothing was sampled this edge.
   typedef enum logic [2:0] {
      CMD_NONE    = 3'd0,
      CMD_ACT     = 3'd1,
      CMD_WR      = 3'd2,
      CMD_RD      = 3'd3,
      CMD_PREAB   = 3'd4,
      CMD_NOP     = 3'd5,
      CMD_ILLEGAL = 3'd6
   } cmd_t;

endpackage

// File: rtl/ddr5_dram_responder_if.sv
// ----------------------------------------------------------------------------
// ddr5_dram_responder_if
// Command/address bus between a DDR5 controller (master) and the responder
// (slave).
//   CS  chip select, active-low
//   CA  14-bit command/address bus
// Handshake: there is no valid/ready pair. CS low at a rising mem_clk edge is
// the strobe that qualifies CA; the slave has no backpressure and must accept
// (or flag) every strobed command on the edge it is presented.
// ----------------------------------------------------------------------------
interface ddr5_dram_responder_if;

   logic        CS;
   logic [13:0] CA;

   modport master (output CS, output CA);
   modport slave  (input  CS, input  CA);

endinterface

// File: rtl/ddr5_ca_decoder.sv
// ----------------------------------------------------------------------------
// ddr5_ca_decoder
// Purely combinational CS/CA decoder.
// Ports:
//   cs       in   chip select, active-low
//   ca       in   14-bit command/address bus
//   cmd      out  decoded command (CMD_NONE when cs is high)
//   row      out  raw row field CA[13:2]
//   col      out  raw column field CA[13:5]
//   illegal  out  cs low with an unrecognised opcode
// ----------------------------------------------------------------------------
module ddr5_ca_decoder
   import ddr5_resp_pkg::*;
(
   input  logic                   cs,
   input  logic [CA_W-1:0]        ca,
   output cmd_t                   cmd,
   output logic [ROW_FIELD_W-1:0] row,
   output logic [COL_FIELD_W-1:0] col,
   output logic                   illegal
);

   always_comb begin
      cmd     = CMD_NONE;
      illegal = 1'b0;
      row     = ca[13:2];
      col     = ca[13:5];
      if (!cs) begin
         // ACT owns the whole CA[1:0]=00 space, so it is checked first.
         if (ca[1:0] == OP_ACT) begin
            cmd = CMD_ACT;
         end else begin
            case (ca[4:0])
               OP_WR:    cmd = CMD_WR;
               OP_RD:    cmd = CMD_RD;
               OP_PREAB: cmd = CMD_PREAB;
               OP_NOP:   cmd = CMD_NOP;
               default: begin
                  cmd     = CMD_ILLEGAL;
                  illegal = 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/ddr5_dram_responder.sv
// ----------------------------------------------------------------------------
// ddr5_dram_responder
// Single-rank, single-bank DDR5 device responder. Decodes ACT/WR/RD/PREab/NOP
// from the CS/CA bus, stores write bursts in an internal array and returns
// read bursts on DQ after a fixed read latency.
// Parameters: ROW_W, COL_W (address bits kept), BL (beats per burst),
//             RL / WL (read / write latency), TRCD (ACT to RD/WR minimum).
// Ports:
//   mem_clk  in     memory clock, rising edge
//   rst_n    in     asynchronous active-low reset
//   ca_bus   slave  CS / CA command bus (ddr5_dram_responder_if)
//   DQ       inout  16-bit data bus, driven only while dq_oe=1
//   dq_oe    out    responder is driving DQ
//   err      out    one-cycle pulse on a protocol violation
//   state_o  out    current FSM state (debug)
// Build option: define DDR5_RESP_TIMING_CHECK_EN to flag RD/WR issued fewer
// than TRCD cycles after ACT (the command still executes).
// ----------------------------------------------------------------------------
module ddr5_dram_responder
   import ddr5_resp_pkg::*;
#(
   parameter int ROW_W = 6,
   parameter int COL_W = 4,
   parameter int BL    = 2,
   parameter int RL    = 4,
   parameter int WL    = 3,
   parameter int TRCD  = 3
) (
   input  logic                    mem_clk,
   input  logic                    rst_n,
   ddr5_dram_responder_if.slave    ca_bus,
   inout  wire  [DQ_W-1:0]         DQ,
   output logic                    dq_oe,
   output logic                    err,
   output logic [2:0]              state_o
);

   localparam int AW      = ROW_W + COL_W;
   localparam int DEPTH   = 1 << AW;
   localparam int LAT_MAX = (RL > WL) ? RL : WL;
   localparam int LW      = $clog2(LAT_MAX + 1);
   localparam int BW      = $clog2(BL + 1);

   // ---------------------------------------------------------------------
   // Command decode
   // ---------------------------------------------------------------------
   cmd_t                   dec_cmd;
   logic [ROW_FIELD_W-1:0] dec_row;
   logic [COL_FIELD_W-1:0] dec_col;
   logic                   dec_illegal;

   ddr5_ca_decoder u_ca_decoder (
      .cs      (ca_bus.CS),
      .ca      (ca_bus.CA),
      .cmd     (dec_cmd),
      .row     (dec_row),
      .col     (dec_col),
      .illegal (dec_illegal)
   );

   // Upper row/column bits beyond ROW_W/COL_W are intentionally dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{dec_row, dec_col};

   // Anything other than NOP while a burst is in flight is a violation.
   logic burst_cmd_err;
   assign burst_cmd_err = (dec_cmd != CMD_NONE) && (dec_cmd != CMD_NOP);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t            state;
   logic [ROW_W-1:0]  open_row;
   logic [COL_W-1:0]  burst_col;
   logic [LW-1:0]     lat_cnt;
   logic [BW-1:0]     beat_cnt;
   logic [DQ_W-1:0]   dq_q;
   logic [DQ_W-1:0]   mem [DEPTH];

   // ---------------------------------------------------------------------
   // ACT-to-RD/WR spacing check
   // ---------------------------------------------------------------------
   logic trcd_violation;

`ifdef DDR5_RESP_TIMING_CHECK_EN
   localparam int TW = $clog2(TRCD + 2);
   logic [TW-1:0] trcd_cnt;

   // Holds the number of edges since the accepted ACT, saturating at TRCD.
   // Out of reset it starts saturated so no stale violation is reported.
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         trcd_cnt <= TW'(TRCD);
      end else if (state == IDLE && dec_cmd == CMD_ACT) begin
         trcd_cnt <= TW'(1);
      end else if (trcd_cnt < TW'(TRCD)) begin
         trcd_cnt <= trcd_cnt + 1'b1;
      end
   end

   assign trcd_violation = (trcd_cnt < TW'(TRCD));
`else
   assign trcd_violation = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Beat addressing and write enable
   // ---------------------------------------------------------------------
   // Beat 0 is handled on the edge that leaves the WAIT state, so the beat
   // index is forced to zero there; in the DATA states beat_cnt is the index.
   logic [BW-1:0] beat_sel;
   logic [AW-1:0] beat_addr;
   logic          mem_we;

   always_comb begin
      beat_sel = beat_cnt;
      if (state == WR_WAIT || state == RD_WAIT) begin
         beat_sel = '0;
      end
      // Column wraps within the row; the row never increments.
      beat_addr = {open_row, burst_col + COL_W'(beat_sel)};
      mem_we    = ((state == WR_WAIT) && (lat_cnt == LW'(WL))) ||
                  (state == WR_DATA);
   end

   // Storage is deliberately not reset; a reset mid-write keeps the beats
   // that already landed.
   always_ff @(posedge mem_clk) begin
      if (mem_we) begin
         mem[beat_addr] <= DQ;
      end
   end

   // ---------------------------------------------------------------------
   // Main FSM
   // lat_cnt is loaded with 1 on the RD/WR edge N, so it equals m at edge
   // N+m; data starts on the edge where it reaches the latency.
   // ---------------------------------------------------------------------
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         open_row  <= '0;
         burst_col <= '0;
         lat_cnt   <= '0;
         beat_cnt  <= '0;
         dq_oe     <= 1'b0;
         dq_q      <= '0;
         err       <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               case (dec_cmd)
                  CMD_ACT: begin
                     open_row <= dec_row[ROW_W-1:0];
                     state    <= ACTIVE;
                  end
                  CMD_WR, CMD_RD, CMD_ILLEGAL: err <= 1'b1;
                  default: ;
               endcase
            end

            ACTIVE: begin
               case (dec_cmd)
                  CMD_WR: begin
                     burst_col <= dec_col[COL_W-1:0];
                     lat_cnt   <= LW'(1);
                     err       <= trcd_violation;
                     state     <= WR_WAIT;
                  end
                  CMD_RD: begin
                     burst_col <= dec_col[COL_W-1:0];
                     lat_cnt   <= LW'(1);
                     err       <= trcd_violation;
                     state     <= RD_WAIT;
                  end
                  CMD_PREAB: state <= IDLE;
                  // A second ACT leaves the open row untouched.
                  CMD_ACT, CMD_ILLEGAL: err <= 1'b1;
                  default: ;
               endcase
            end

            WR_WAIT: begin
               err <= burst_cmd_err;
               if (lat_cnt == LW'(WL)) begin
                  // Beat 0 is captured by mem_we on this same edge.
                  beat_cnt <= BW'(1);
                  state    <= (BL == 1) ? ACTIVE : WR_DATA;
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end

            WR_DATA: begin
               err <= burst_cmd_err;
               if (beat_cnt == BW'(BL - 1)) begin
                  state <= ACTIVE;
               end else begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end

            RD_WAIT: begin
               err <= burst_cmd_err;
               if (lat_cnt == LW'(RL)) begin
                  dq_oe    <= 1'b1;
                  dq_q     <= mem[beat_addr];
                  beat_cnt <= BW'(1);
                  state    <= RD_DATA;
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end

            RD_DATA: begin
               err <= burst_cmd_err;
               // One extra edge after the last beat releases the bus.
               if (beat_cnt == BW'(BL)) begin
                  dq_oe <= 1'b0;
                  state <= ACTIVE;
               end else begin
                  dq_q     <= mem[beat_addr];
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   // Illegal opcodes are already covered by CMD_ILLEGAL in every state.
   logic unused_illegal;
   assign unused_illegal = dec_illegal;

   assign state_o = state;
   assign DQ      = dq_oe ? dq_q : {DQ_W{1'bz}};

endmodule
